// File: rtl/control_sequencer.sv
// control_sequencer: fetch/issue FSM with a registered ISSUE->FETCH hop (2 cycles per instruction); stall holds issue and the PC.
// The optional illegal-opcode trap (class 111 -> sticky illegal + HALT) is enabled with `define CTRL_ILLEGAL_TRAP_EN.
`timescale 1ns/1ps
module control_sequencer #(
  parameter int unsigned      PC_W     = 8,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            instr_req,
  output logic [PC_W-1:0] instr_addr,
  input  logic            instr_ack,
  input  logic [15:0]     instr_data,
  input  logic            stall,
  input  logic [3:0]      flag_ex,
  output logic [4:0]      op_dec,
  output logic [4:0]      RW_dec,
  output logic            mem_en_dec,
  output logic            mem_rw_dec,
  output logic            mem_mux_sel_dec,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            illegal
);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [2:0] CLS_NOP   = 3'b000;
  localparam logic [2:0] CLS_ALU   = 3'b001;
  localparam logic [2:0] CLS_LOAD  = 3'b010;
  localparam logic [2:0] CLS_STORE = 3'b011;
  localparam logic [2:0] CLS_JMP   = 3'b100;
  localparam logic [2:0] CLS_BR    = 3'b101;
  localparam logic [2:0] CLS_HALT  = 3'b110;
  localparam logic [2:0] CLS_ILL   = 3'b111;

  state_e          state_q, state_d;
  logic [15:0]     ir_q, ir_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            instr_req_q, instr_req_d;
  logic            halted_q, halted_d;
  logic [4:0]      op_q, op_d;
  logic [4:0]      rw_q, rw_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_rw_q, mem_rw_d;
  logic            mux_q, mux_d;

  // Instruction fields of the latched word
  logic [2:0]      cls;
  logic [4:0]      aop;
  logic [4:0]      rd;
  logic [PC_W-1:0] target;
  logic [1:0]      cond;
  logic            pol;

  assign cls    = ir_q[15:13];
  assign aop    = ir_q[12:8];
  assign rd     = ir_q[7:3];
  assign target = PC_W'(ir_q[7:0]);
  assign cond   = ir_q[9:8];
  assign pol    = ir_q[10];

  logic            commit;
  logic            trap;
  logic            br_taken;
  logic [PC_W-1:0] pc_inc;

  assign commit   = (state_q == ST_ISSUE) && !stall;
  assign br_taken = flag_ex[cond] ^ pol;
  assign pc_inc   = pc_q + PC_W'(1);

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign trap = (cls == CLS_ILL);
`else
  assign trap = 1'b0;
`endif

  // Decoded values for the latched word; bubble unless the class drives the datapath
  logic [4:0]      dec_op, dec_rw;
  logic            dec_en, dec_wr, dec_mux, dec_halt;
  logic [PC_W-1:0] dec_pc;

  always_comb begin
    dec_op   = 5'd0;
    dec_rw   = 5'd0;
    dec_en   = 1'b0;
    dec_wr   = 1'b0;
    dec_mux  = 1'b0;
    dec_halt = 1'b0;
    dec_pc   = pc_inc;
    case (cls)
      CLS_NOP: ;
      CLS_ALU: begin
        dec_op = aop;
        dec_rw = rd;
      end
      CLS_LOAD: begin
        dec_op  = aop;
        dec_rw  = rd;
        dec_en  = 1'b1;
        dec_mux = 1'b1;
      end
      CLS_STORE: begin
        dec_op = aop;
        dec_en = 1'b1;
        dec_wr = 1'b1;
      end
      CLS_JMP:  dec_pc = target;
      CLS_BR:   dec_pc = br_taken ? target : pc_inc;
      CLS_HALT: begin
        dec_halt = 1'b1;
        dec_pc   = pc_q;
      end
      CLS_ILL: begin
        if (trap) begin
          dec_halt = 1'b1;
          dec_pc   = pc_q;
        end
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:   state_d = ST_FETCH;
      ST_FETCH: if (instr_ack) state_d = ST_ISSUE;
      ST_ISSUE: if (commit) state_d = dec_halt ? ST_HALT : ST_FETCH;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RST;
    endcase
  end

  // Output logic: outputs are registered from the next state so they line up with it
  always_comb begin
    instr_req_d = (state_d == ST_FETCH);
    halted_d    = (state_d == ST_HALT);
    ir_d        = ir_q;
    pc_d        = pc_q;
    op_d        = 5'd0;
    rw_d        = 5'd0;
    mem_en_d    = 1'b0;
    mem_rw_d    = 1'b0;
    mux_d       = 1'b0;
    if ((state_q == ST_FETCH) && instr_ack) begin
      ir_d = instr_data;
    end
    if (commit) begin
      pc_d     = dec_pc;
      op_d     = dec_op;
      rw_d     = dec_rw;
      mem_en_d = dec_en;
      mem_rw_d = dec_wr;
      mux_d    = dec_mux;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_q        <= 16'd0;
      pc_q        <= RESET_PC;
      instr_req_q <= 1'b0;
      halted_q    <= 1'b0;
      op_q        <= 5'd0;
      rw_q        <= 5'd0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      mux_q       <= 1'b0;
    end else begin
      ir_q        <= ir_d;
      pc_q        <= pc_d;
      instr_req_q <= instr_req_d;
      halted_q    <= halted_d;
      op_q        <= op_d;
      rw_q        <= rw_d;
      mem_en_q    <= mem_en_d;
      mem_rw_q    <= mem_rw_d;
      mux_q       <= mux_d;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  assign illegal_d = illegal_q | (commit & trap);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign instr_req       = instr_req_q;
  assign instr_addr      = pc_q;
  assign pc              = pc_q;
  assign halted          = halted_q;
  assign op_dec          = op_q;
  assign RW_dec          = rw_q;
  assign mem_en_dec      = mem_en_q;
  assign mem_rw_dec      = mem_rw_q;
  assign mem_mux_sel_dec = mux_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: one program run through ALU, stalled LOAD, branches, wrap, JMP, resets, HALT and class 111.
`timescale 1ns/1ps
module tb_control_sequencer;

  logic        clk;
  logic        reset;
  logic        instr_req;
  logic [7:0]  instr_addr;
  logic        instr_ack;
  logic [15:0] instr_data;
  logic        stall;
  logic [3:0]  flag_ex;
  logic [4:0]  op_dec;
  logic [4:0]  RW_dec;
  logic        mem_en_dec;
  logic        mem_rw_dec;
  logic        mem_mux_sel_dec;
  logic [7:0]  pc;
  logic        halted;
  logic        illegal;

  logic [15:0] imem [0:255];
  int checks;
  int errors;

  assign instr_data = imem[instr_addr];

  control_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk             (clk),
    .reset           (reset),
    .instr_req       (instr_req),
    .instr_addr      (instr_addr),
    .instr_ack       (instr_ack),
    .instr_data      (instr_data),
    .stall           (stall),
    .flag_ex         (flag_ex),
    .op_dec          (op_dec),
    .RW_dec          (RW_dec),
    .mem_en_dec      (mem_en_dec),
    .mem_rw_dec      (mem_rw_dec),
    .mem_mux_sel_dec (mem_mux_sel_dec),
    .pc              (pc),
    .halted          (halted),
    .illegal         (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (instr_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", instr_req); end
    checks++; if (instr_addr !== 8'h00) begin errors++; $display("FAIL rst_addr: got %h want 00", instr_addr); end
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL rst_pc: got %h want 00", pc); end
    checks++; if ({op_dec, RW_dec, mem_en_dec, mem_rw_dec, mem_mux_sel_dec} !== 13'd0) begin
      errors++; $display("FAIL rst_decode: got op=%h rw=%h mem=%b%b%b want all 0", op_dec, RW_dec, mem_en_dec, mem_rw_dec, mem_mux_sel_dec);
    end
    checks++; if ({halted, illegal} !== 2'b00) begin errors++; $display("FAIL rst_flags: got halted=%b illegal=%b want 0 0", halted, illegal); end
    reset = 1'b1;
    tick();
    checks++; if ({instr_req, instr_addr} !== {1'b1, 8'h00}) begin
      errors++; $display("FAIL first_fetch: got req=%b addr=%h want 1 00", instr_req, instr_addr);
    end
  endtask

  task automatic test_alu();
    tick();
    checks++; if (instr_req !== 1'b0) begin errors++; $display("FAIL req_drop_after_ack: got %b want 0", instr_req); end
    tick();
    checks++; if ({op_dec, RW_dec} !== {5'b00101, 5'd5}) begin
      errors++; $display("FAIL alu_decode: got op=%b rw=%0d want 00101 5", op_dec, RW_dec);
    end
    checks++; if ({mem_en_dec, mem_rw_dec, mem_mux_sel_dec} !== 3'b000) begin
      errors++; $display("FAIL alu_mem: got %b%b%b want 000", mem_en_dec, mem_rw_dec, mem_mux_sel_dec);
    end
    checks++; if (pc !== 8'h01) begin errors++; $display("FAIL alu_pc: got %h want 01", pc); end
    imem[0] = 16'h8080;
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({op_dec, RW_dec, mem_en_dec} !== 11'd0) begin
        errors++; $display("FAIL stall_bubble%0d: got op=%h rw=%h en=%b want 0", i, op_dec, RW_dec, mem_en_dec);
      end
    end
    stall = 1'b0;
    tick();
    checks++; if ({op_dec, RW_dec} !== {5'b11001, 5'd10}) begin
      errors++; $display("FAIL load_decode: got op=%b rw=%0d want 11001 10", op_dec, RW_dec);
    end
    checks++; if ({mem_en_dec, mem_rw_dec, mem_mux_sel_dec} !== 3'b101) begin
      errors++; $display("FAIL load_mem: got %b%b%b want 101", mem_en_dec, mem_rw_dec, mem_mux_sel_dec);
    end
    checks++; if (pc !== 8'h02) begin errors++; $display("FAIL load_pc: got %h want 02", pc); end
    tick();
    checks++; if ({op_dec, mem_en_dec} !== 6'd0) begin
      errors++; $display("FAIL load_then_bubble: got op=%h en=%b want 0", op_dec, mem_en_dec);
    end
  endtask

  task automatic test_branch();
    flag_ex = 4'b0001;
    tick();
    checks++; if ({pc, instr_addr} !== {8'h40, 8'h40}) begin
      errors++; $display("FAIL br_taken: got pc=%h addr=%h want 40 40", pc, instr_addr);
    end
    checks++; if (op_dec !== 5'd0) begin errors++; $display("FAIL br_bubble: got op=%h want 0", op_dec); end
    tick();
    flag_ex = 4'b1110;
    tick();
    checks++; if (pc !== 8'h41) begin errors++; $display("FAIL br_not_taken: got pc=%h want 41", pc); end
  endtask

  task automatic test_wrap_jmp();
    repeat (2) tick();
    checks++; if (pc !== 8'hFF) begin errors++; $display("FAIL jmp_ff: got pc=%h want ff", pc); end
    repeat (2) tick();
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL pc_wrap: got pc=%h want 00", pc); end
    repeat (2) tick();
    checks++; if ({instr_req, instr_addr} !== {1'b1, 8'h80}) begin
      errors++; $display("FAIL jmp_addr: got req=%b addr=%h want 1 80", instr_req, instr_addr);
    end
  endtask

  task automatic test_reset_mid_fetch();
    instr_ack = 1'b0;
    tick();
    checks++; if ({instr_req, instr_addr} !== {1'b1, 8'h80}) begin
      errors++; $display("FAIL fetch_wait: got req=%b addr=%h want 1 80", instr_req, instr_addr);
    end
    #2 reset = 1'b0;
    #1;
    checks++; if ({instr_req, pc, instr_addr} !== {1'b0, 8'h00, 8'h00}) begin
      errors++; $display("FAIL async_reset: got req=%b pc=%h addr=%h want 0 00 00", instr_req, pc, instr_addr);
    end
  endtask

  task automatic test_halt();
    imem[0] = 16'hC000;
    instr_ack = 1'b1;
    reset = 1'b1;
    repeat (3) tick();
    checks++; if ({halted, instr_req, op_dec} !== {1'b1, 1'b0, 5'd0}) begin
      errors++; $display("FAIL halt_enter: got halted=%b req=%b op=%h want 1 0 0", halted, instr_req, op_dec);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if ({halted, instr_req} !== 2'b10) begin
        errors++; $display("FAIL halt_hold%0d: got halted=%b req=%b want 1 0", i, halted, instr_req);
      end
    end
  endtask

  task automatic test_illegal();
    reset = 1'b0;
    #1;
    imem[0] = 16'hE000;
    reset = 1'b1;
    repeat (3) tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
    checks++; if ({illegal, halted, instr_req, pc} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
      errors++; $display("FAIL ill_trap: got illegal=%b halted=%b req=%b pc=%h want 1 1 0 00", illegal, halted, instr_req, pc);
    end
    repeat (3) tick();
    checks++; if ({illegal, halted} !== 2'b11) begin
      errors++; $display("FAIL ill_sticky: got illegal=%b halted=%b want 1 1", illegal, halted);
    end
`else
    checks++; if ({illegal, halted, instr_req, pc} !== {1'b0, 1'b0, 1'b1, 8'h01}) begin
      errors++; $display("FAIL ill_nop: got illegal=%b halted=%b req=%b pc=%h want 0 0 1 01", illegal, halted, instr_req, pc);
    end
    repeat (3) tick();
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_tied: got %b want 0", illegal); end
`endif
    checks++; if (op_dec !== 5'd0) begin errors++; $display("FAIL ill_bubble: got op=%h want 0", op_dec); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    instr_ack = 1'b1;
    stall     = 1'b0;
    flag_ex   = 4'b0000;
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    imem[8'h00] = 16'h2528;
    imem[8'h01] = 16'h5950;
    imem[8'h02] = 16'hA040;
    imem[8'h40] = 16'hA040;
    imem[8'h41] = 16'h80FF;
    imem[8'hFF] = 16'h0000;
    imem[8'h80] = 16'hC000;

    test_reset();
    test_alu();
    test_stall();
    test_branch();
    test_wrap_jmp();
    test_reset_mid_fetch();
    test_halt();
    test_illegal();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
